// File: rtl/bus_pkg.sv
// Shared definitions for the shared-bus arbiter: FSM encoding and width helper.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN  = 2'b01,
      TURN = 2'b10
   } state_e;

   // Index width that never collapses to zero bits for single-entry cases.
   function automatic int clog2_min1(input int value);
      return ($clog2(value) < 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin priority encoder: first requester above `last_i`, wrapping modulo N.
module rr_pick
   import bus_pkg::*;
#(
   parameter  int N  = 8,
   localparam int IW = clog2_min1(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic          valid_o,
   output logic [IW-1:0] idx_o
);

   int            cand;
   logic [IW-1:0] cand_idx;

   // Scan from the farthest offset down so the nearest requester is written last.
   always_comb begin
      valid_o  = |req_i;
      idx_o    = '0;
      cand     = 0;
      cand_idx = '0;
      for (int i = N; i >= 1; i--) begin
         cand = int'(last_i) + i;
         if (cand >= N) cand = cand - N;
         cand_idx = IW'(cand);
         if (req_i[cand_idx]) idx_o = cand_idx;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared W-bit bus with hold limit and one-cycle turnaround.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter  int N        = 8,
   parameter  int W        = 32,
   parameter  int MAX_HOLD = 16,
   localparam int OW       = clog2_min1(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [W*N-1:0] a,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   g_n,
   output logic [W-1:0]   y,
   output logic           busy,
   output logic [OW-1:0]  owner
);

   localparam int            HW        = clog2_min1(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
   localparam logic [OW-1:0] LAST_RST  = OW'(N - 1);

   state_e        state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [OW-1:0] last_q, last_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          pick_valid;
   logic [OW-1:0] pick_idx;
   logic          others;
   logic          release_own;
   logic [W-1:0]  slice [N];
   logic [W-1:0]  y_or;

   rr_pick #(.N(N)) u_pick (
      .req_i   (req),
      .last_i  (last_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         last_q  <= LAST_RST;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   // Limit test is >= so a contender arriving after the counter saturated is still served.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      last_d      = last_q;
      hold_d      = hold_q;
      others      = |(req & ~gnt_q);
      release_own = !req[last_q] ||
                    ((MAX_HOLD != 0) && (hold_q >= HOLD_LAST) && others);
      case (state_q)
         IDLE, TURN: begin
            gnt_d = '0;
            if (pick_valid) begin
               state_d         = OWN;
               gnt_d[pick_idx] = 1'b1;
               last_d          = pick_idx;
               hold_d          = '0;
            end else begin
               state_d = IDLE;
            end
         end
         OWN: begin
            if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
            if (release_own) begin
               state_d = TURN;
               gnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   for (genvar i = 0; i < N; i++) begin : g_slice
      assign slice[i] = a[i*W +: W] & {W{gnt_q[i]}};
   end

   always_comb begin
      y_or = '0;
      for (int i = 0; i < N; i++) y_or = y_or | slice[i];
   end

   assign gnt   = gnt_q;
   assign g_n   = ~gnt_q;
   assign y     = y_or;
   assign busy  = |gnt_q;
   assign owner = (state_q == OWN) ? last_q : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected grants are queued with each stimulus step.
module tb_bus_arbiter;

   localparam int N        = 8;
   localparam int W        = 32;
   localparam int MAX_HOLD = 4;
   localparam int OW       = 3;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [W*N-1:0] a;
   logic [N-1:0]   gnt;
   logic [N-1:0]   g_n;
   logic [W-1:0]   y;
   logic           busy;
   logic [OW-1:0]  owner;

   logic [N-1:0]   exp_q[$];
   string          phase;
   int             checks;
   int             errors;

   bus_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .a     (a),
      .gnt   (gnt),
      .g_n   (g_n),
      .y     (y),
      .busy  (busy),
      .owner (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [OW-1:0] idx_of(input logic [N-1:0] v);
      idx_of = '0;
      for (int i = 0; i < N; i++) if (v[i]) idx_of = OW'(i);
   endfunction

   function automatic logic [W-1:0] bus_of(input logic [N-1:0] v);
      bus_of = '0;
      for (int i = 0; i < N; i++) if (v[i]) bus_of = bus_of | a[i*W +: W];
   endfunction

   task automatic check_now(input logic [N-1:0] eg);
      checks++;
      assert (gnt === eg) else begin
         errors++;
         $error("FAIL %s gnt: got %h expected %h", phase, gnt, eg);
      end
      checks++;
      assert (g_n === ~eg) else begin
         errors++;
         $error("FAIL %s g_n: got %h expected %h", phase, g_n, ~eg);
      end
      checks++;
      assert (y === bus_of(eg)) else begin
         errors++;
         $error("FAIL %s y: got %h expected %h", phase, y, bus_of(eg));
      end
      checks++;
      assert (busy === (|eg)) else begin
         errors++;
         $error("FAIL %s busy: got %b expected %b", phase, busy, |eg);
      end
      checks++;
      assert (owner === idx_of(eg)) else begin
         errors++;
         $error("FAIL %s owner: got %0d expected %0d", phase, owner, idx_of(eg));
      end
   endtask

   // Drive req now; the grant it produces is checked at the next falling edge.
   task automatic step(input logic [N-1:0] r, input logic [N-1:0] eg);
      logic [N-1:0] e;
      req = r;
      exp_q.push_back(eg);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard: got empty queue expected entry", phase);
      end else begin
         e = exp_q.pop_front();
         check_now(e);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      req    = '0;
      for (int i = 0; i < N; i++) a[i*W +: W] = $urandom_range(32'hFFFF_FFFE, 1);
      a[2*W +: W] = 32'hDEADBEEF;

      phase = "reset";
      repeat (2) @(negedge clk);
      check_now('0);
      rst_n = 1'b1;

      phase = "idle";
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);

      phase = "single";
      step(8'h04, 8'h04);
      checks++;
      assert (y === 32'hDEADBEEF) else begin
         errors++;
         $error("FAIL single_y: got %h expected %h", y, 32'hDEADBEEF);
      end
      step(8'h04, 8'h04);
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);

      phase = "reset_mid";
      step(8'h08, 8'h08);
      step(8'h08, 8'h08);
      #2 rst_n = 1'b0;
      #1 check_now('0);
      @(negedge clk);
      check_now('0);
      rst_n = 1'b1;
      step(8'h09, 8'h01);

      phase = "round_robin";
      for (int k = 0; k < N; k++) begin
         step(8'hFF, N'(1) << k);
         step(8'hFF & ~(N'(1) << k), 8'h00);
         step(8'hFF, N'(1) << ((k + 1) % N));
      end
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);

      phase = "hold_limit";
      step(8'h02, 8'h02);
      step(8'h22, 8'h02);
      step(8'h22, 8'h02);
      step(8'h22, 8'h02);
      step(8'h22, 8'h00);
      step(8'h22, 8'h20);
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);

      phase = "no_contention";
      for (int c = 0; c < 40; c++) step(8'h40, 8'h40);
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);

      phase = "turn_arrival";
      step(8'h01, 8'h01);
      step(8'h01, 8'h01);
      step(8'h00, 8'h00);
      step(8'h80, 8'h80);
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);

      phase = "drop_at_limit";
      step(8'h04, 8'h04);
      step(8'h0C, 8'h04);
      step(8'h0C, 8'h04);
      step(8'h0C, 8'h04);
      step(8'h08, 8'h00);
      step(8'h08, 8'h08);
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
